// File: rtl/top_level_design.sv
// Sequential 8x8 unsigned multiplier: one 4x4 multiplier, shifter and 16-bit accumulator, four compute cycles.
// Optional seven-segment progress decoder enabled by defining SEVEN_SEG_EN; otherwise seg_a..seg_g are tied low.
module top_level_design (
  input  logic        clk,
  input  logic        reset_a,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  input  logic        start,
  output logic        done_flag,
  output logic [15:0] product8x8_out,
  output logic        seg_a,
  output logic        seg_b,
  output logic        seg_c,
  output logic        seg_d,
  output logic        seg_e,
  output logic        seg_f,
  output logic        seg_g
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LSB  = 3'd1,
    MID1 = 3'd2,
    MID2 = 3'd3,
    MSB  = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;

  logic [3:0]  mul_a, mul_b;
  logic [7:0]  pp;
  logic [3:0]  shamt;
  logic [15:0] pp_shift;
  logic [15:0] acc_sum;
  logic [6:0]  seg;

  // Nibble and shift selection for the partial product of the current step
  always_comb begin
    mul_a = a_q[3:0];
    mul_b = b_q[3:0];
    shamt = 4'd0;
    case (state_q)
      MID1: begin
        mul_b = b_q[7:4];
        shamt = 4'd4;
      end
      MID2: begin
        mul_a = a_q[7:4];
        shamt = 4'd4;
      end
      MSB: begin
        mul_a = a_q[7:4];
        mul_b = b_q[7:4];
        shamt = 4'd8;
      end
      default: ;
    endcase
  end

  assign pp       = {4'b0000, mul_a} * {4'b0000, mul_b};
  assign pp_shift = {8'h00, pp} << shamt;
  assign acc_sum  = acc_q + pp_shift;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          a_d     = dataa;
          b_d     = datab;
          acc_d   = '0;
          state_d = LSB;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      LSB, MID1, MID2, MSB: begin
        if (start) begin
          state_d = ERR;
        end else begin
          acc_d = acc_sum;
          case (state_q)
            LSB:     state_d = MID1;
            MID1:    state_d = MID2;
            MID2:    state_d = MSB;
            default: state_d = DONE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  assign done_flag      = (state_q == DONE);
  assign product8x8_out = acc_q;

`ifdef SEVEN_SEG_EN
  always_comb begin
    seg = 7'b0000000;
    case (state_q)
      IDLE:    seg = 7'b1111110;
      LSB:     seg = 7'b0110000;
      MID1:    seg = 7'b1101101;
      MID2:    seg = 7'b1111001;
      MSB:     seg = 7'b0110011;
      DONE:    seg = 7'b0111101;
      ERR:     seg = 7'b1001111;
      default: seg = 7'b0000000;
    endcase
  end
`else
  assign seg = '0;
`endif

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;

endmodule

// File: tb/tb_top_level_design.sv
// Self-checking bench for top_level_design: directed scenarios plus random traffic against a behavioural model.
// Segment expectations follow SEVEN_SEG_EN the same way the design does.
module tb_top_level_design;

  logic        clk;
  logic        reset_a;
  logic [7:0]  dataa, datab;
  logic        start;
  logic        done_flag;
  logic [15:0] product8x8_out;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  top_level_design dut (
    .clk            (clk),
    .reset_a        (reset_a),
    .dataa          (dataa),
    .datab          (datab),
    .start          (start),
    .done_flag      (done_flag),
    .product8x8_out (product8x8_out),
    .seg_a          (seg_a),
    .seg_b          (seg_b),
    .seg_c          (seg_c),
    .seg_d          (seg_d),
    .seg_e          (seg_e),
    .seg_f          (seg_f),
    .seg_g          (seg_g)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: phase 0 idle, 1..4 = steps still to perform (next one is phase), 5 done, 6 error
  int unsigned m_phase = 0;
  int unsigned m_a = 0, m_b = 0, m_acc = 0;

  function automatic int unsigned sum_upto(int unsigned a, int unsigned b, int unsigned n);
    int unsigned t[4];
    int unsigned s;
    t[0] = (a % 16) * (b % 16);
    t[1] = (a % 16) * (b / 16) * 16;
    t[2] = (a / 16) * (b % 16) * 16;
    t[3] = (a / 16) * (b / 16) * 256;
    s = 0;
    for (int unsigned i = 0; i < n; i++) s += t[i];
    return s % 65536;
  endfunction

  function automatic logic [6:0] exp_seg(int unsigned ph);
`ifdef SEVEN_SEG_EN
    case (ph)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b0111101;
      default: return 7'b1001111;
    endcase
`else
    return (ph > 100) ? 7'b1111111 : 7'b0000000;
`endif
  endfunction

  always @(posedge clk) begin
    if (reset_a) begin
      m_phase <= 0;
      m_a     <= 0;
      m_b     <= 0;
      m_acc   <= 0;
    end else if (m_phase == 0 || m_phase == 5 || m_phase == 6) begin
      if (start) begin
        m_a     <= dataa;
        m_b     <= datab;
        m_acc   <= 0;
        m_phase <= 1;
      end else if (m_phase == 5) begin
        m_phase <= 0;
      end
    end else begin
      if (start) begin
        m_phase <= 6;
      end else begin
        m_acc   <= sum_upto(m_a, m_b, m_phase);
        m_phase <= m_phase + 1;
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_product", product8x8_out, m_acc);
      chk("model_done", done_flag, (m_phase == 5) ? 1 : 0);
      chk("model_seg", {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}, exp_seg(m_phase));
    end
  end

  // Called at a negedge; leaves the bench at the negedge where done is seen (state DONE).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int unsigned expv, input string name);
    int unsigned seen;
    seen = 0;
    start = 1; dataa = a; datab = b;
    for (int unsigned i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = 0;
      dataa = 8'($urandom);
      datab = 8'($urandom);
      if (done_flag === 1'b1) begin
        seen = i;
        break;
      end
    end
    chk({name, "_latency"}, seen, 5);
    chk({name, "_product"}, product8x8_out, expv);
  endtask

  initial begin
    reset_a = 1; start = 0; dataa = 0; datab = 0;
    repeat (2) @(negedge clk);
    reset_a = 0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_product", product8x8_out, 0);
    chk("reset_done", done_flag, 0);
    chk("reset_seg", {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}, exp_seg(0));

    run_op(100, 100, 10000, "op100x100");
    run_op(60, 200, 12000, "op60x200");
    run_op(12, 90, 1080, "op12x90");
    run_op(255, 255, 65025, "op255x255");
    run_op(0, 173, 0, "op0x173");
    @(negedge clk);
    @(negedge clk);

    // Reset two cycles into an operation
    start = 1; dataa = 44; datab = 190;
    @(negedge clk); start = 0;
    @(negedge clk); reset_a = 1;
    @(negedge clk); reset_a = 0;
    chk("abort_reset_product", product8x8_out, 0);
    chk("abort_reset_done", done_flag, 0);
    run_op(65, 111, 7215, "op65x111");
    @(negedge clk);

    // Start re-asserted while in MID1: ACC keeps the LSB term 5*9
    start = 1; dataa = 37; datab = 201;
    @(negedge clk); start = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (3) begin
      chk("err_product_frozen", product8x8_out, 45);
      chk("err_done_low", done_flag, 0);
      @(negedge clk);
    end
    run_op(15, 17, 255, "op15x17");
    run_op(200, 3, 600, "op200x3_b2b");
    @(negedge clk);

    // Random traffic with occasional aborts and resets
    for (int unsigned i = 0; i < 400; i++) begin
      start   = ($urandom_range(0, 4) == 0);
      dataa   = 8'($urandom);
      datab   = 8'($urandom);
      reset_a = ($urandom_range(0, 60) == 0);
      @(negedge clk);
    end
    start = 0; reset_a = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
